// File: rtl/dm_csr_file.sv
// Debug-module CSR file: data registers, AbstractCS and Command with a fixed-latency command engine.
// Latency: read data and rvalid_o registered, one cycle after the request; a command runs BUSY_CYCLES cycles.
// Backpressure: none; every access is accepted, and writes that collide with a running command are dropped and flag cmderr.
module dm_csr_file #(
    parameter int DATA_COUNT  = 2,
    parameter int BUSY_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [6:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        busy_o
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_BUSY    = 1'b1;
    localparam logic [7:0] ADDR_DATA0 = 8'h04;
    localparam logic [7:0] ADDR_ABSCS = 8'h16;
    localparam logic [7:0] ADDR_CMD   = 8'h17;
    localparam logic [7:0] DATA_END   = 8'(4 + DATA_COUNT);
    localparam logic [7:0] BUSY_LOAD  = 8'(BUSY_CYCLES);
    localparam logic [3:0] DC_FIELD   = 4'(DATA_COUNT);

    logic [0:0]  r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_cmd;
    logic [2:0]  r_cmderr;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    logic [7:0]  w_addr;
    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic        w_is_data;
    logic        w_is_abscs;
    logic        w_is_cmd;
    logic [3:0]  w_idx;
    logic        w_data_we;
    logic        w_cmd_start;
    logic        w_busy_viol;
    logic        w_done;
    logic [31:0] w_rd_val;
    logic [31:0] w_data [12];

    assign w_addr     = {1'b0, addr_i};
    assign w_wr       = req_i & we_i;
    assign w_rd       = req_i & ~we_i;
    assign w_busy     = (r_state == ST_BUSY);
    assign w_is_data  = (w_addr >= ADDR_DATA0) && (w_addr < DATA_END);
    assign w_is_abscs = (w_addr == ADDR_ABSCS);
    assign w_is_cmd   = (w_addr == ADDR_CMD);
    assign w_idx      = w_addr[3:0] - 4'd4;

    assign w_data_we   = w_wr & w_is_data & ~w_busy;
    assign w_cmd_start = w_wr & w_is_cmd & ~w_busy & (r_cmderr == 3'd0);
    assign w_busy_viol = w_wr & w_busy & (w_is_cmd | w_is_data);
    // Completion edge: the counter steps from 1 to 0 here.
    assign w_done      = w_busy & (r_cnt == 8'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_data
            if (gi < DATA_COUNT) begin : g_impl
                logic [31:0] r_val;
                logic        w_we;
                assign w_we = w_data_we && (w_idx == 4'(gi));
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        r_val <= '0;
                    end else if (gi == 0 && w_done) begin
                        r_val <= r_val + {16'b0, r_cmd[15:0]};
                    end else if (w_we) begin
                        r_val <= wdata_i;
                    end
                end
                assign w_data[gi] = r_val;
            end else begin : g_none
                assign w_data[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cmd   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_start) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= BUSY_LOAD;
                        r_cmd   <= wdata_i;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmderr <= '0;
        end else if (w_wr && w_is_abscs) begin
            r_cmderr <= r_cmderr & ~wdata_i[10:8];
        end else if (w_busy_viol && r_cmderr == 3'd0) begin
            r_cmderr <= 3'd1;
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (w_is_data) begin
            w_rd_val = w_data[w_idx];
        end else if (w_is_abscs) begin
            w_rd_val = {19'b0, w_busy, 1'b0, r_cmderr, 4'b0, DC_FIELD};
        end else if (w_is_cmd) begin
            w_rd_val = r_cmd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            r_rdata  <= w_rd ? w_rd_val : 32'd0;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign busy_o   = w_busy;

endmodule

// File: tb/tb_dm_csr_file.sv
// Bench for dm_csr_file: a 2-register/4-cycle instance and a 12-register/1-cycle instance.
// Reads push expected data and cycle into a queue; per-instance monitors pop on rvalid_o.
// No backpressure in the DUT; monitors also flag missing or unexpected responses.
module tb_dm_csr_file;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [6:0]  addr_a = '0, addr_b = '0;
    logic [31:0] wdata_a = '0, wdata_b = '0;
    logic        rvalid_a, rvalid_b, busy_a, busy_b;
    logic [31:0] rdata_a, rdata_b;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dm_csr_file #(.DATA_COUNT(2), .BUSY_CYCLES(4)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
        .wdata_i(wdata_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .busy_o(busy_a)
    );

    dm_csr_file #(.DATA_COUNT(12), .BUSY_CYCLES(1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
        .wdata_i(wdata_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .busy_o(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rvalid_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                chk(e.name, rdata_a, e.dat);
            end
        end else if (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
            e = q_a.pop_front();
            chk({e.name, "_missing_rvalid"}, 32'd0, 32'd1);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rvalid_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                chk(e.name, rdata_b, e.dat);
            end
        end else if (q_b.size() != 0 && q_b[0].cyc <= cyc) begin
            e = q_b.pop_front();
            chk({e.name, "_missing_rvalid"}, 32'd0, 32'd1);
        end
    end

    task automatic wr(input bit b, input logic [7:0] a, input logic [31:0] d);
        if (b) begin
            req_b = 1'b1; we_b = 1'b1; addr_b = a[6:0]; wdata_b = d;
        end else begin
            req_a = 1'b1; we_a = 1'b1; addr_a = a[6:0]; wdata_a = d;
        end
        @(posedge clk); #1;
        req_a = 1'b0; we_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic rd(input bit b, input logic [7:0] a, input logic [31:0] exp, input string nm);
        exp_t x;
        x.cyc  = cyc + 1;
        x.dat  = exp;
        x.name = nm;
        if (b) begin
            q_b.push_back(x);
            req_b = 1'b1; we_b = 1'b0; addr_b = a[6:0];
        end else begin
            q_a.push_back(x);
            req_a = 1'b1; we_a = 1'b0; addr_a = a[6:0];
        end
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Samples busy_o on the next n falling edges; reports count and the first sample.
    task automatic busy_cnt(input bit b, input int n, output int hi, output bit first);
        hi = 0;
        first = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ((b ? busy_b : busy_a) === 1'b1) hi++;
            if (i == 0) first = (b ? busy_b : busy_a);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        bit first;

        repeat (3) @(posedge clk);
        #1;
        chk("a_reset_rvalid", 32'(rvalid_a), 32'd0);
        chk("a_reset_rdata", rdata_a, 32'd0);
        chk("a_reset_busy", 32'(busy_a), 32'd0);
        chk("b_reset_rvalid", 32'(rvalid_b), 32'd0);
        chk("b_reset_rdata", rdata_b, 32'd0);
        chk("b_reset_busy", 32'(busy_b), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        rd(0, 8'h16, 32'h0000_0002, "a_abscs_reset");
        rd(0, 8'h20, 32'h0000_0000, "a_unmapped_20");
        wr(0, 8'h04, 32'hA5A5_0001);
        wr(0, 8'h05, 32'h1234_5678);
        rd(0, 8'h04, 32'hA5A5_0001, "a_data0");
        rd(0, 8'h05, 32'h1234_5678, "a_data1");
        rd(0, 8'h06, 32'h0000_0000, "a_unimpl_06");
        wr(0, 8'h06, 32'hFFFF_FFFF);
        wr(0, 8'h0F, 32'hFFFF_FFFF);
        rd(0, 8'h06, 32'h0000_0000, "a_unimpl_06_after_wr");
        rd(0, 8'h16, 32'h0000_0002, "a_abscs_no_cmderr");
        rd(0, 8'h7F, 32'h0000_0000, "a_unmapped_7f");

        // Completion wraps Data0 modulo 2^32.
        wr(0, 8'h04, 32'hFFFF_FFF0);
        wr(0, 8'h17, 32'h0000_0020);
        busy_cnt(0, 8, hi, first);
        chk("a_busy_first_cycle", 32'(first), 32'd1);
        chk("a_busy_len", 32'(hi), 32'd4);
        rd(0, 8'h04, 32'h0000_0010, "a_data0_wrap");
        rd(0, 8'h17, 32'h0000_0020, "a_cmd_readback");

        // Collisions while busy; the last read lands on the completion edge and sees the old value.
        wr(0, 8'h17, 32'h0000_0005);
        wr(0, 8'h04, 32'h0000_DEAD);
        wr(0, 8'h17, 32'h0000_0009);
        rd(0, 8'h16, 32'h0000_1102, "a_abscs_busy_err");
        rd(0, 8'h04, 32'h0000_0010, "a_data0_read_busy");
        idle(2);
        chk("a_busy_done", 32'(busy_a), 32'd0);
        rd(0, 8'h16, 32'h0000_0102, "a_abscs_err_idle");
        rd(0, 8'h04, 32'h0000_0015, "a_data0_after_cmd5");
        wr(0, 8'h17, 32'h0000_0007);
        busy_cnt(0, 4, hi, first);
        chk("a_cmd_blocked_by_err", 32'(hi), 32'd0);
        rd(0, 8'h17, 32'h0000_0005, "a_cmd_unchanged");
        wr(0, 8'h16, 32'h0000_0700);
        rd(0, 8'h16, 32'h0000_0002, "a_abscs_cleared");
        wr(0, 8'h17, 32'h0000_0001);
        busy_cnt(0, 8, hi, first);
        chk("a_busy_len_after_clear", 32'(hi), 32'd4);
        rd(0, 8'h04, 32'h0000_0016, "a_data0_after_cmd1");

        // Reset in the second busy cycle aborts the command.
        wr(0, 8'h17, 32'h0000_0010);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("a_rst_busy_async", 32'(busy_a), 32'd0);
        chk("a_rst_rvalid_async", 32'(rvalid_a), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rd(0, 8'h04, 32'h0000_0000, "a_data0_after_abort");
        rd(0, 8'h16, 32'h0000_0002, "a_abscs_after_abort");
        rd(0, 8'h17, 32'h0000_0000, "a_cmd_after_abort");
        wr(0, 8'h17, 32'h0000_0003);
        busy_cnt(0, 8, hi, first);
        chk("a_busy_len_after_rst", 32'(hi), 32'd4);
        rd(0, 8'h04, 32'h0000_0003, "a_data0_after_cmd3");

        // Full 12-register build with single-cycle commands.
        rd(1, 8'h16, 32'h0000_000C, "b_abscs_dc12");
        wr(1, 8'h0F, 32'hCAFE_F00D);
        wr(1, 8'h0E, 32'h0BAD_BEEF);
        rd(1, 8'h0F, 32'hCAFE_F00D, "b_data11");
        rd(1, 8'h0E, 32'h0BAD_BEEF, "b_data10");
        rd(1, 8'h10, 32'h0000_0000, "b_unmapped_10");
        wr(1, 8'h04, 32'h0000_0005);
        wr(1, 8'h17, 32'h0001_0002);
        busy_cnt(1, 4, hi, first);
        chk("b_busy_first_cycle", 32'(first), 32'd1);
        chk("b_busy_len", 32'(hi), 32'd1);
        rd(1, 8'h17, 32'h0001_0002, "b_cmd_readback");
        rd(1, 8'h04, 32'h0000_0007, "b_data0_low16_add");

        idle(3);
        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
